// File: rtl/switch_event_pkg.sv
// Shared types and constants for the switch event scheduler.
// Contents: FSM state enum, default debounce length, synchroniser depth,
// overrun counter width.
package switch_event_pkg;

    typedef enum logic [1:0] {
        S_INIT,
        S_SCAN,
        S_HOLD
    } state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 100000;
    localparam int unsigned SYNC_STAGES             = 2;
    localparam int unsigned OVERRUN_W               = 16;

endpackage

// File: rtl/switch_debounce_cell.sv
// One switch: two-flop synchroniser, debounce counter, stable-level flop and
// a one-cycle "done" strobe raised on the cycle the stable level is updated.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   sw_i       - raw asynchronous switch level
//   en_i       - debounce active (scan/hold states)
//   load_i     - load stable level directly from the synchroniser (no event)
//   stable_o   - debounced level
//   done_o     - combinational strobe: stable level changes on this edge
module switch_debounce_cell
    import switch_event_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    input  logic en_i,
    input  logic load_i,
    output logic stable_o,
    output logic done_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign stable_o = stable_q;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        done_o   = 1'b0;
        if (load_i) begin
            stable_d = sync_lvl;
            cnt_d    = '0;
        end else if (en_i) begin
            if (sync_lvl == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = sync_lvl;
                cnt_d    = '0;
                done_o   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/switch_event_scheduler.sv
// Debounces NUM_SW board switches, queues each stable-level change as a
// pending event and hands events one at a time to a consumer over
// valid/ready, choosing among pending switches round-robin.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   sw_in        - raw switch levels
//   sw_stable    - debounced levels
//   ev_valid     - event presented; held with ev_index/ev_value until ev_ready
//   ev_ready     - consumer accept
//   ev_index     - switch that changed
//   ev_value     - its stable level at grant time
//   overrun_cnt  - saturating count of cycles in which a change merged into
//                  an already pending event (only with SWITCH_EVENT_OVERRUN_EN)
module switch_event_scheduler
    import switch_event_pkg::*;
#(
    parameter int unsigned NUM_SW          = 8,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 17,
    parameter int unsigned IDX_W           = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_in,
    output logic [NUM_SW-1:0] sw_stable,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [IDX_W-1:0]  ev_index,
    output logic              ev_value
`ifdef SWITCH_EVENT_OVERRUN_EN
    ,
    output logic [OVERRUN_W-1:0] overrun_cnt
`endif
);

    state_e            state_q, state_d;
    logic [1:0]        init_cnt_q, init_cnt_d;
    logic [NUM_SW-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              ev_valid_q, ev_valid_d;
    logic [IDX_W-1:0]  ev_index_q, ev_index_d;
    logic              ev_value_q, ev_value_d;

    logic [NUM_SW-1:0] done;
    logic [NUM_SW-1:0] clr;
    logic              deb_en;
    logic              load;
    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand;
    int unsigned       sum;

    assign deb_en = (state_q == S_SCAN) || (state_q == S_HOLD);

    for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
        switch_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .sw_i    (sw_in[i]),
            .en_i    (deb_en),
            .load_i  (load),
            .stable_o(sw_stable[i]),
            .done_o  (done[i])
        );
    end

    // Round-robin search: first pending bit at or above ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = 0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_SW; k++) begin
            sum = 32'(ptr_q) + k;
            if (sum >= NUM_SW) begin
                sum = sum - NUM_SW;
            end
            cand = IDX_W'(sum);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ptr_d      = ptr_q;
        ev_valid_d = ev_valid_q;
        ev_index_d = ev_index_q;
        ev_value_d = ev_value_q;
        clr        = '0;
        load       = 1'b0;
        case (state_q)
            S_INIT: begin
                // Let the synchronisers fill before adopting their level.
                if (init_cnt_q == 2'(SYNC_STAGES)) begin
                    load    = 1'b1;
                    state_d = S_SCAN;
                end else begin
                    init_cnt_d = init_cnt_q + 2'd1;
                end
            end
            S_SCAN: begin
                if (grant_found) begin
                    ev_valid_d     = 1'b1;
                    ev_index_d     = grant_idx;
                    ev_value_d     = sw_stable[grant_idx];
                    clr[grant_idx] = 1'b1;
                    ptr_d          = (grant_idx == IDX_W'(NUM_SW - 1)) ? '0
                                                                       : grant_idx + IDX_W'(1);
                    state_d        = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ev_ready) begin
                    ev_valid_d = 1'b0;
                    state_d    = S_SCAN;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Set has priority so a change landing in its own grant cycle survives.
    assign pending_d = (pending_q & ~clr) | done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            pending_q  <= '0;
            ptr_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_index_q <= '0;
            ev_value_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            ev_valid_q <= ev_valid_d;
            ev_index_q <= ev_index_d;
            ev_value_q <= ev_value_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_index = ev_index_q;
    assign ev_value = ev_value_q;

`ifdef SWITCH_EVENT_OVERRUN_EN
    logic [OVERRUN_W-1:0] overrun_q, overrun_d;
    logic                 merge_any;

    assign merge_any = |(done & pending_q & ~clr);

    always_comb begin
        overrun_d = overrun_q;
        if (merge_any && (overrun_q != '1)) begin
            overrun_d = overrun_q + OVERRUN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_cnt = overrun_q;
`endif

endmodule

// File: doc/switch_event_scheduler.md
Name: switch_event_scheduler

Overview:
- Watches NUM_SW raw board switches and synchronises and debounces each one.
- Detects a change of each switch's stable level and queues it as a pending event.
- Serialises the pending events to a single consumer over a valid/ready handshake, using a round-robin arbiter.
- Sits between the board switch pins and the game/control FSMs, replacing per-switch ad-hoc change detectors.

Parameters:
- NUM_SW, 8, number of switch inputs (2..16).
- DEBOUNCE_CYCLES, 100000, cycles a synchronised level must differ from the stable level before it is accepted (>=1).
- CNT_W, 17, debounce counter width; must hold DEBOUNCE_CYCLES-1.
- IDX_W, 3, event index width, equal to $clog2(NUM_SW).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sw_in  in  NUM_SW  raw asynchronous switch levels.
- sw_stable  out  NUM_SW  debounced stable level per switch.
- ev_valid  out  1  event presented.
- ev_ready  in  1  consumer accepts the event when ev_valid & ev_ready.
- ev_index  out  IDX_W  index of the switch that changed.
- ev_value  out  1  new stable level of that switch.
- overrun_cnt  out  16  saturating count of lost events; present only with the macro.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state clears on a clk edge with rst=1.
- Reset values:
  - sw_stable=0, ev_valid=0, ev_index=0, ev_value=0.
  - pending=0, round-robin pointer=0, all debounce counters=0, 2-flop synchronisers=0.
  - state=S_INIT.
- Synchroniser: two flops per switch; sync[i] lags sw_in[i] by 2 cycles.
- S_INIT:
  - Waits 2 cycles after reset deassertion so the synchronisers fill.
  - Then loads sw_stable<=sync with no pending set, so there are no power-up events.
  - Goes to S_SCAN.
- Debounce, per switch, active in S_SCAN and S_HOLD:
  - If sync[i]==sw_stable[i]: cnt[i]<=0.
  - Otherwise cnt[i] increments. When cnt[i]==DEBOUNCE_CYCLES-1 and the level still differs, sw_stable[i]<=sync[i], cnt[i]<=0, and pending[i] is set.
  - Latency from sw_in edge to pending set is 2+DEBOUNCE_CYCLES cycles.
  - Pulses shorter than DEBOUNCE_CYCLES are ignored.
- S_SCAN:
  - If pending is nonzero, grant the first set bit searching upward from ptr, wrapping at NUM_SW-1.
  - On grant: ev_index<=grant, ev_value<=sw_stable[grant], ev_valid<=1, clear pending[grant], ptr<=grant+1 (wrap), go to S_HOLD.
  - If nothing is pending, stay in S_SCAN.
- S_HOLD:
  - ev_valid, ev_index and ev_value are held constant until ev_ready=1.
  - On the accepting edge: ev_valid<=0, go to S_SCAN.
  - Minimum spacing between events is 2 cycles.
- Simultaneous set and clear of the same pending bit: set wins, so a change that lands in the grant cycle is not lost.
- A change of the granted switch during S_HOLD sets pending again and produces a follow-up event.
- A change while pending[i] is already 1 merges. The later event reports sw_stable at grant time, so a switch that toggled twice may report its original level.
- ev_ready while ev_valid=0 is ignored.
- rst mid-S_HOLD: ev_valid=0 after that edge and the event is discarded.

Optional Feature:
- Macro: SWITCH_EVENT_OVERRUN_EN.
- Defined:
  - overrun_cnt port exists.
  - Increments by 1 (saturating at 16'hFFFF) on any cycle where at least one switch completes debounce while its pending bit is already 1 and is not being cleared that cycle.
  - Multiple merges in one cycle count once.
  - Cleared by rst.
- Undefined: the port and counter are absent; merge behaviour is unchanged.

Decomposition:
- Package switch_event_pkg holds:
  - the state enum {S_INIT, S_SCAN, S_HOLD};
  - DEFAULT_DEBOUNCE_CYCLES=100000;
  - SYNC_STAGES=2;
  - OVERRUN_W=16.
- Sub-module switch_debounce_cell (synchroniser, counter, stable flop and a "done" strobe) is instantiated NUM_SW times in a generate loop.
- Arbiter and FSM stay in the top module.

Test Plan:
- Reset with sw_in=8'hA5 and DEBOUNCE_CYCLES=4 -> sw_stable=8'hA5 four cycles after rst drops; ev_valid stays 0 for 50 cycles.
- sw_in[3] goes 0->1 and is held, ev_ready=1 -> ev_valid rises 2+4+1 cycles later (+1 from the S_SCAN grant, bringing the total to 2+DEBOUNCE_CYCLES+1) with ev_index=3 and ev_value=1; exactly one event.
- sw_in[6] pulses high for 3 cycles (<4) -> no event; sw_stable[6] stays 0.
- sw_in[0] and sw_in[5] toggle on the same cycle, ev_ready=1 -> events index 0 then index 5, 2 cycles apart; a repeat toggle of both then yields 0 then 5 again (ptr wrap).
- ev_ready held 0 for 20 cycles during an event -> ev_valid, ev_index and ev_value are constant throughout; pulse rst on cycle 10 -> ev_valid=0 on the next cycle.
- With SWITCH_EVENT_OVERRUN_EN, ev_ready=0: sw1 changes twice (each change debounced) while pending -> overrun_cnt=1 and a single event for index 1 is delivered once ready.
